// File: rtl/ctrl_pipe_pkg.sv
// Shared constants for the control-signal pipeline: stage indices, bubble fill
// and the bit layout of one stage record.
package ctrl_pipe_pkg;

    localparam int unsigned ST_EX  = 0;
    localparam int unsigned ST_MEM = 1;
    localparam int unsigned ST_WB  = 2;

    // A bubble is the all-zero record, so downstream sees no side effect
    localparam logic BUBBLE_BIT = 1'b0;

    // Record layout, LSB first: rf_en, load, rd, ctrl, valid
    localparam int unsigned OFS_RF_EN = 0;
    localparam int unsigned OFS_LOAD  = 1;
    localparam int unsigned OFS_RD    = 2;

    function automatic int unsigned ofs_ctrl(input int unsigned reg_w);
        return OFS_RD + reg_w;
    endfunction

    function automatic int unsigned ofs_valid(input int unsigned ctrl_w, input int unsigned reg_w);
        return OFS_RD + reg_w + ctrl_w;
    endfunction

    function automatic int unsigned rec_w(input int unsigned ctrl_w, input int unsigned reg_w);
        return ofs_valid(ctrl_w, reg_w) + 1;
    endfunction

endpackage

// File: rtl/ctrl_pipe_hz_stage.sv
// One pipeline stage register: hold wins over clear, clear loads a bubble.
module pipe_stage_reg #(
    parameter int unsigned W = 1
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         hold,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (!hold) begin
            data_d = clear ? '0 : d;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/ctrl_pipe_hz.sv
// Control-bundle pipeline from ID through STAGES stages with stall, flush,
// load-use bubble insertion and saturating bubble/stall counters.
module ctrl_pipe_hz
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned STAGES = 3,
    parameter int unsigned REG_W  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     CLK,
    input  logic                     CLR,
    input  logic                     id_valid,
    input  logic [CTRL_W-1:0]        id_ctrl,
    input  logic                     id_load,
    input  logic                     id_rf_en,
    input  logic [REG_W-1:0]         id_rd,
    input  logic [REG_W-1:0]         id_rn,
    input  logic [REG_W-1:0]         id_rm,
    input  logic                     id_use_rn,
    input  logic                     id_use_rm,
    input  logic                     ext_stall,
    input  logic                     flush,
    output logic [STAGES-1:0]        st_valid,
    output logic [STAGES*CTRL_W-1:0] st_ctrl,
    output logic [STAGES*REG_W-1:0]  st_rd,
    output logic [STAGES-1:0]        st_load,
    output logic [STAGES-1:0]        st_rf_en,
    output logic                     hz_stall,
    output logic [CNT_W-1:0]         bubble_cnt,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int unsigned REC_W = rec_w(CTRL_W, REG_W);
    localparam int unsigned OFS_C = ofs_ctrl(REG_W);
    localparam int unsigned OFS_V = ofs_valid(CTRL_W, REG_W);

    logic [REC_W-1:0] rec_q [STAGES];
    logic [REC_W-1:0] id_rec_c;
    logic             bubble_c;
    logic             ex_valid_c;
    logic             ex_load_c;
    logic             ex_rf_en_c;
    logic [REG_W-1:0] ex_rd_c;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Fields are zeroed when ID holds nothing real
    assign id_rec_c = id_valid ? {1'b1, id_ctrl, id_rd, id_load, id_rf_en}
                               : {REC_W{BUBBLE_BIT}};

    assign ex_valid_c = rec_q[ST_EX][OFS_V];
    assign ex_load_c  = rec_q[ST_EX][OFS_LOAD];
    assign ex_rf_en_c = rec_q[ST_EX][OFS_RF_EN];
    assign ex_rd_c    = rec_q[ST_EX][OFS_RD +: REG_W];

    // A flushed instruction never needs a stall, so flush masks the hazard
    assign hz_stall = !flush && id_valid && ex_valid_c && ex_load_c && ex_rf_en_c
                   && ((id_use_rn && (id_rn == ex_rd_c)) || (id_use_rm && (id_rm == ex_rd_c)));
    assign bubble_c = flush || hz_stall;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic [REC_W-1:0] d_c;
        logic             clear_c;

        if (g == 0) begin : g_head
            assign d_c     = id_rec_c;
            assign clear_c = bubble_c;
        end else begin : g_tail
            assign d_c     = rec_q[g-1];
            assign clear_c = 1'b0;
        end

        pipe_stage_reg #(.W(REC_W)) u_stage (
            .CLK   (CLK),
            .CLR   (CLR),
            .hold  (ext_stall),
            .clear (clear_c),
            .d     (d_c),
            .q     (rec_q[g])
        );

        assign st_valid[g]                 = rec_q[g][OFS_V];
        assign st_ctrl[g*CTRL_W +: CTRL_W] = rec_q[g][OFS_C +: CTRL_W];
        assign st_rd[g*REG_W +: REG_W]     = rec_q[g][OFS_RD +: REG_W];
        assign st_load[g]                  = rec_q[g][OFS_LOAD];
        assign st_rf_en[g]                 = rec_q[g][OFS_RF_EN];
    end

    // Saturating counters; bubbles only count on edges that actually advance
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (ext_stall) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else if (bubble_c && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            bubble_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_hz.sv
// Self-checking bench for ctrl_pipe_hz against a record-level pipeline model.
module tb_ctrl_pipe_hz;

    localparam int unsigned CTRL_W = 16;
    localparam int unsigned STAGES = 3;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned STW    = STAGES * (CTRL_W + REG_W + 3);
    localparam int          CMAX   = (1 << CNT_W) - 1;

    logic                     CLK = 1'b0;
    logic                     CLR = 1'b0;
    logic                     id_valid = 1'b0;
    logic [CTRL_W-1:0]        id_ctrl = '0;
    logic                     id_load = 1'b0;
    logic                     id_rf_en = 1'b0;
    logic [REG_W-1:0]         id_rd = '0;
    logic [REG_W-1:0]         id_rn = '0;
    logic [REG_W-1:0]         id_rm = '0;
    logic                     id_use_rn = 1'b0;
    logic                     id_use_rm = 1'b0;
    logic                     ext_stall = 1'b0;
    logic                     flush = 1'b0;
    logic [STAGES-1:0]        st_valid;
    logic [STAGES*CTRL_W-1:0] st_ctrl;
    logic [STAGES*REG_W-1:0]  st_rd;
    logic [STAGES-1:0]        st_load;
    logic [STAGES-1:0]        st_rf_en;
    logic                     hz_stall;
    logic [CNT_W-1:0]         bubble_cnt;
    logic [CNT_W-1:0]         stall_cnt;

    int checks = 0;
    int failures = 0;

    ctrl_pipe_hz #(.CTRL_W(CTRL_W), .STAGES(STAGES), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .CLR(CLR), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_load(id_load),
        .id_rf_en(id_rf_en), .id_rd(id_rd), .id_rn(id_rn), .id_rm(id_rm),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .ext_stall(ext_stall), .flush(flush),
        .st_valid(st_valid), .st_ctrl(st_ctrl), .st_rd(st_rd), .st_load(st_load),
        .st_rf_en(st_rf_en), .hz_stall(hz_stall), .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    // Reference model: one record per stage, plus integer counters
    typedef struct {
        logic              v;
        logic [CTRL_W-1:0] c;
        logic [REG_W-1:0]  rd;
        logic              ld;
        logic              rf;
    } rec_t;

    rec_t m[STAGES];
    int   m_bub;
    int   m_stl;

    task automatic m_clear();
        for (int i = 0; i < STAGES; i++) m[i] = '{v: 1'b0, c: '0, rd: '0, ld: 1'b0, rf: 1'b0};
        m_bub = 0;
        m_stl = 0;
    endtask

    function automatic logic m_hz();
        logic match;
        match = (id_use_rn && id_rn == m[0].rd) || (id_use_rm && id_rm == m[0].rd);
        return !flush && id_valid && m[0].v && m[0].ld && m[0].rf && match;
    endfunction

    function automatic logic [STW-1:0] exp_state();
        logic [STAGES-1:0]        v, l, f;
        logic [STAGES*CTRL_W-1:0] c;
        logic [STAGES*REG_W-1:0]  r;
        for (int i = 0; i < STAGES; i++) begin
            v[i] = m[i].v;
            l[i] = m[i].ld;
            f[i] = m[i].rf;
            c[i*CTRL_W +: CTRL_W] = m[i].c;
            r[i*REG_W +: REG_W]   = m[i].rd;
        end
        return {v, c, r, l, f};
    endfunction

    function automatic logic [STW-1:0] dut_state();
        return {st_valid, st_ctrl, st_rd, st_load, st_rf_en};
    endfunction

    // Advance one edge in both DUT and model; ends 1 time unit after the edge
    task automatic tick();
        logic hz;
        hz = m_hz();
        @(posedge CLK);
        if (ext_stall) begin
            if (m_stl < CMAX) m_stl++;
        end else begin
            for (int i = STAGES - 1; i > 0; i--) m[i] = m[i-1];
            if (flush || hz) begin
                m[0] = '{v: 1'b0, c: '0, rd: '0, ld: 1'b0, rf: 1'b0};
                if (m_bub < CMAX) m_bub++;
            end else if (id_valid) begin
                m[0] = '{v: 1'b1, c: id_ctrl, rd: id_rd, ld: id_load, rf: id_rf_en};
            end else begin
                m[0] = '{v: 1'b0, c: '0, rd: '0, ld: 1'b0, rf: 1'b0};
            end
        end
        #1;
    endtask

    task automatic set_id(input logic v, input logic ld, input logic rf, input logic [REG_W-1:0] rd,
                          input logic urn, input logic [REG_W-1:0] rn,
                          input logic urm, input logic [REG_W-1:0] rm);
        id_valid = v; id_load = ld; id_rf_en = rf; id_rd = rd;
        id_use_rn = urn; id_rn = rn; id_use_rm = urm; id_rm = rm;
        id_ctrl = CTRL_W'($urandom);
    endtask

    task automatic apply_reset();
        CLR = 1'b0;
        flush = 1'b0;
        ext_stall = 1'b0;
        set_id(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        #2;
        m_clear();
        @(negedge CLK);
        CLR = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        CLR = 1'b0;
        set_id(1'b1, 1'b0, 1'b1, 4'd3, 1'b0, '0, 1'b0, '0);
        id_ctrl = 16'hFFFF;
        #1;
        m_clear();
        checks++;
        if (dut_state() !== '0) begin
            failures++; $display("FAIL reset_state: got %h want 0", dut_state());
        end
        checks++;
        if ({hz_stall, bubble_cnt, stall_cnt} !== '0) begin
            failures++; $display("FAIL reset_hz_cnt: got hz=%b bub=%h stl=%h want 0", hz_stall, bubble_cnt, stall_cnt);
        end
        @(negedge CLK);
        CLR = 1'b1;
        repeat (3) tick();
        checks++;
        if (st_ctrl[2*CTRL_W +: CTRL_W] !== 16'hFFFF || st_valid !== 3'b111) begin
            failures++; $display("FAIL reset_release_fill: got ctrl2=%h valid=%b want ffff 111", st_ctrl[2*CTRL_W +: CTRL_W], st_valid);
        end
        checks++;
        if (dut_state() !== exp_state()) begin
            failures++; $display("FAIL reset_release_model: got %h want %h", dut_state(), exp_state());
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        set_id(1'b1, 1'b1, 1'b1, 4'd5, 1'b0, '0, 1'b0, '0);
        tick();
        set_id(1'b1, 1'b0, 1'b1, REG_W'($urandom), 1'b1, 4'd5, 1'b0, 4'd9);
        #1;
        checks++;
        if (hz_stall !== 1'b1) begin
            failures++; $display("FAIL load_use_hz: got %b want 1", hz_stall);
        end
        tick();
        checks++;
        if (st_valid[0] !== 1'b0 || st_rd[REG_W +: REG_W] !== 4'd5 || st_load[1] !== 1'b1 || bubble_cnt !== 4'd1) begin
            failures++; $display("FAIL load_use_bubble: got v0=%b rd1=%h ld1=%b bub=%h want 0 5 1 1", st_valid[0], st_rd[REG_W +: REG_W], st_load[1], bubble_cnt);
        end
        checks++;
        if (hz_stall !== 1'b0) begin
            failures++; $display("FAIL load_use_release: got %b want 0", hz_stall);
        end
        tick();
        checks++;
        if (dut_state() !== exp_state()) begin
            failures++; $display("FAIL load_use_after: got %h want %h", dut_state(), exp_state());
        end
    endtask

    task automatic test_no_false_hazard();
        apply_reset();
        set_id(1'b1, 1'b1, 1'b1, 4'd5, 1'b0, '0, 1'b0, '0);
        tick();
        set_id(1'b1, 1'b0, 1'b1, 4'd7, 1'b1, 4'd6, 1'b0, 4'd5);
        #1;
        checks++;
        if (hz_stall !== 1'b0) begin
            failures++; $display("FAIL no_false_hz: got %b want 0", hz_stall);
        end
        tick();
        checks++;
        if (st_valid[0] !== 1'b1 || st_rd[REG_W-1:0] !== 4'd7 || bubble_cnt !== 4'd0) begin
            failures++; $display("FAIL no_false_shift: got v0=%b rd0=%h bub=%h want 1 7 0", st_valid[0], st_rd[REG_W-1:0], bubble_cnt);
        end
    endtask

    task automatic test_flush_hazard();
        logic [CNT_W-1:0] b0;
        apply_reset();
        set_id(1'b1, 1'b1, 1'b1, 4'd5, 1'b0, '0, 1'b0, '0);
        tick();
        set_id(1'b1, 1'b0, 1'b1, 4'd1, 1'b1, 4'd5, 1'b1, 4'd5);
        flush = 1'b1;
        #1;
        b0 = bubble_cnt;
        checks++;
        if (hz_stall !== 1'b0) begin
            failures++; $display("FAIL flush_hz: got %b want 0", hz_stall);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (st_valid[0] !== 1'b0 || bubble_cnt !== b0 + CNT_W'(1) || st_rd[REG_W +: REG_W] !== 4'd5) begin
            failures++; $display("FAIL flush_bubble: got v0=%b bub=%h rd1=%h want 0 %h 5", st_valid[0], bubble_cnt, st_rd[REG_W +: REG_W], b0 + CNT_W'(1));
        end
    endtask

    task automatic test_ext_stall();
        logic [STW-1:0] snap;
        apply_reset();
        set_id(1'b1, 1'b0, 1'b1, 4'd1, 1'b0, '0, 1'b0, '0);
        tick();
        set_id(1'b1, 1'b0, 1'b0, 4'd3, 1'b0, '0, 1'b0, '0);
        tick();
        set_id(1'b1, 1'b1, 1'b1, 4'd2, 1'b0, '0, 1'b0, '0);
        tick();
        snap = exp_state();
        ext_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_id(1'b1, 1'b0, 1'b1, REG_W'($urandom), 1'b1, 4'd2, 1'b0, '0);
            #1;
            checks++;
            if (hz_stall !== 1'b1) begin
                failures++; $display("FAIL stall_hz_held: cycle %0d got %b want 1", i, hz_stall);
            end
            tick();
            checks++;
            if (dut_state() !== snap) begin
                failures++; $display("FAIL stall_hold: cycle %0d got %h want %h", i, dut_state(), snap);
            end
        end
        checks++;
        if (stall_cnt !== 4'd4 || bubble_cnt !== 4'd0) begin
            failures++; $display("FAIL stall_cnt: got stl=%h bub=%h want 4 0", stall_cnt, bubble_cnt);
        end
        ext_stall = 1'b0;
        tick();
        checks++;
        if (st_valid !== 3'b110 || dut_state() !== exp_state()) begin
            failures++; $display("FAIL stall_resume: got %h want %h", dut_state(), exp_state());
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 300; n++) begin
            set_id(($urandom % 4) != 0, $urandom % 2, $urandom % 2, REG_W'($urandom % 4),
                   $urandom % 2, REG_W'($urandom % 4), $urandom % 2, REG_W'($urandom % 4));
            flush = ($urandom % 8) == 0;
            ext_stall = ($urandom % 6) == 0;
            #1;
            checks++;
            if (hz_stall !== m_hz()) begin
                failures++; $display("FAIL rand_hz: step %0d got %b want %b", n, hz_stall, m_hz());
            end
            tick();
            checks++;
            if (dut_state() !== exp_state() || bubble_cnt !== CNT_W'(m_bub) || stall_cnt !== CNT_W'(m_stl)) begin
                failures++; $display("FAIL rand_state: step %0d got %h %h %h want %h %h %h", n, dut_state(), bubble_cnt, stall_cnt, exp_state(), CNT_W'(m_bub), CNT_W'(m_stl));
            end
        end
        flush = 1'b0;
        ext_stall = 1'b0;
    endtask

    task automatic test_saturation();
        apply_reset();
        flush = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_id(1'b1, 1'b0, 1'b1, REG_W'($urandom), 1'b0, '0, 1'b0, '0);
            tick();
        end
        checks++;
        if (bubble_cnt !== 4'hF || CNT_W'(m_bub) !== bubble_cnt) begin
            failures++; $display("FAIL sat_bubble: got %h want f", bubble_cnt);
        end
        flush = 1'b0;
        repeat (2) tick();
        checks++;
        if (dut_state() !== exp_state() || st_valid !== 3'b011) begin
            failures++; $display("FAIL sat_inflight: got %h want %h", dut_state(), exp_state());
        end
        CLR = 1'b0;
        #2;
        m_clear();
        checks++;
        if (dut_state() !== '0 || bubble_cnt !== '0 || stall_cnt !== '0 || hz_stall !== 1'b0) begin
            failures++; $display("FAIL midrun_reset: got %h bub=%h stl=%h hz=%b want 0", dut_state(), bubble_cnt, stall_cnt, hz_stall);
        end
        @(negedge CLK);
        CLR = 1'b1;
    endtask

    initial begin
        m_clear();
        test_reset();
        test_load_use();
        test_no_false_hazard();
        test_flush_hazard();
        test_ext_stall();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_hz.md
# ctrl_pipe_hz

Parametrised control-signal pipeline for the ARM pipeline datapath. Carries the decoded control bundle from ID through a configurable number of stages (default EX, MEM, WB), with per-cycle stall, branch flush and automatic load-use hazard bubbles. It replaces fixed per-stage control registers and the fixed-select control mux. It also exports the hold signal for the PC and IF/ID registers, plus saturating performance counters.

## Interface
- CTRL_W, 16, width of the control bundle (shift_imm, ALU op, size, mem enable, r/w, S, B, ...)
- STAGES, 3, number of pipeline stages after ID (stage 0 = EX, STAGES-1 = WB); minimum 1
- REG_W, 4, register-index width
- CNT_W, 16, performance counter width
- CLK  in  1  clock, all state on rising edge
- CLR  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  CTRL_W  decoded control bundle from control unit
- id_load, id_rf_en  in  1 each  ID instruction is a load / writes register file
- id_rd, id_rn, id_rm  in  REG_W each  destination and source indices
- id_use_rn, id_use_rm  in  1 each  source actually read
- ext_stall  in  1  freeze whole pipeline (memory busy)
- flush  in  1  branch taken: squash the ID instruction
- st_valid  out  STAGES  per-stage valid
- st_ctrl  out  STAGES*CTRL_W  per-stage bundle, stage i at [i*CTRL_W +: CTRL_W]
- st_rd  out  STAGES*REG_W  per-stage destination
- st_load, st_rf_en  out  STAGES each  per-stage flags
- hz_stall  out  1  hold PC and IF/ID (drive their LE low)
- bubble_cnt, stall_cnt  out  CNT_W each  saturating counters

## Operation
- Each stage register holds {valid, ctrl, rd, load, rf_en}. A bubble is all-zero; no side effect downstream.
- hz_stall = !flush & id_valid & st_valid[0] & st_load[0] & st_rf_en[0] & ((id_use_rn & id_rn==st_rd[0]) | (id_use_rm & id_rm==st_rd[0])).
- Priority at each edge:
  - ext_stall=1: all stages hold; counters except stall_cnt hold.
  - Else flush=1 or hz_stall=1: stage 0 <= bubble; stage i <= stage i-1 for i≥1; bubble_cnt += 1.
  - Else: stage 0 <= {id_valid, id_ctrl, id_rd, id_load, id_rf_en}, gated so fields are zero when id_valid=0; shift as above.
- flush with hazard: flush wins, hz_stall forced 0 (killed instruction needs no stall), one bubble counted.
- stall_cnt += 1 every cycle ext_stall=1.
- Both counters saturate at all-ones; no wrap.
- The WB stage drops out after the edge that overwrites it; no output port beyond stage STAGES-1.

## Timing
- Reset (CLR low, async): every stage valid/ctrl/rd/load/rf_en = 0, counters = 0; hz_stall then 0 regardless of ID inputs.
- Release: CLR sampled high before the edge; first capture on the first rising edge after release.
- Latency: ID bundle appears on stage k outputs k+1 edges after capture, absent stalls; each ext_stall cycle adds one.
- hz_stall is combinational from stage 0 state and ID inputs, valid within the same cycle.
- A load-use pair costs exactly one bubble. Next cycle the load sits in stage 1 and hz_stall deasserts.
- hz_stall stays asserted while ext_stall holds the pipeline, since stage 0 is unchanged.
- Reset mid-operation discards all in-flight stages immediately.

## Structure
- Package ctrl_pipe_pkg: bubble constant (all-zero bundle), stage index constants (EX=0, MEM=1, WB=2), stage record field order.
- Sub-module pipe_stage_reg: one stage, parameter W, ports CLK, CLR, hold, clear, d, q. Instantiated STAGES times in a generate loop.
- Hazard compare and counters stay in the top module.

## Test plan
- Reset: CLR=0 with id_valid=1, ctrl=16'hFFFF -> all outputs 0, hz_stall=0; release, 3 edges -> st_ctrl[2]=16'hFFFF, st_valid=3'b111.
- Load-use: LDR R5 in stage 0, ID uses_rn with rn=5 -> hz_stall=1, next edge stage 0 bubble, stage 1 holds the load, bubble_cnt=1, hz_stall=0.
- No false hazard: stage 0 load to R5, ID rm=5 with id_use_rm=0 -> hz_stall=0, normal shift.
- Flush plus hazard same cycle -> hz_stall=0, one bubble into stage 0, bubble_cnt increments by exactly 1.
- ext_stall held 4 cycles with pipeline full -> all stages unchanged, stall_cnt=4; deassert -> shift resumes.
- Saturation: CNT_W=4, 20 flush cycles -> bubble_cnt=4'hF; then CLR low mid-run -> counters and stages 0.
